// File: rtl/data_mem_responder_if.sv
// Load/store port between the memory stage (master) and the data memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency responder for the 64-bit data memory: one outstanding load/store,
// little-endian byte lanes, alignment and range checking.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [DEPTH];

  logic          accept, enter_resp, mem_wr;
  logic          acc_we, acc_uns;
  logic [1:0]    acc_size;
  logic [63:0]   acc_addr, acc_wdata;
  logic [2:0]    off;
  logic [AW-1:0] idx;
  logic          misaligned, out_of_range, acc_err;
  logic [7:0]    lane_mask;
  logic [63:0]   cur_word, wdata_sh, wr_word, rd_sh, rd_ext;

  assign bus.req_ready = (state_q == S_IDLE) && rst_n;
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // With LATENCY==1 the RAM access happens on the accept edge, so operands come
  // straight from the bus while idle and from the captured copy otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = bus.req_we;
      acc_size  = bus.req_size;
      acc_uns   = bus.req_unsigned;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
    end else begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_uns   = uns_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign off          = acc_addr[2:0];
  assign idx          = acc_addr[3 +: AW];
  assign out_of_range = |acc_addr[63:3+AW];
  assign cur_word     = mem_q[idx];

  always_comb begin
    misaligned = 1'b0;
    lane_mask  = 8'h01;
    case (acc_size)
      2'b00: begin misaligned = 1'b0;         lane_mask = 8'h01; end
      2'b01: begin misaligned = off[0];       lane_mask = 8'h03; end
      2'b10: begin misaligned = |off[1:0];    lane_mask = 8'h0F; end
      2'b11: begin misaligned = |off;         lane_mask = 8'hFF; end
      default: begin misaligned = 1'b1;       lane_mask = 8'h00; end
    endcase
    lane_mask = lane_mask << off;
  end

  assign acc_err  = misaligned || out_of_range;
  assign wdata_sh = acc_wdata << {off, 3'b000};
  assign rd_sh    = cur_word >> {off, 3'b000};

  always_comb begin
    wr_word = cur_word;
    for (int unsigned i = 0; i < 8; i++) begin
      if (lane_mask[i]) wr_word[8*i +: 8] = wdata_sh[8*i +: 8];
    end
  end

  always_comb begin
    rd_ext = '0;
    case (acc_size)
      2'b00: rd_ext = {{56{~acc_uns & rd_sh[7]}},  rd_sh[7:0]};
      2'b01: rd_ext = {{48{~acc_uns & rd_sh[15]}}, rd_sh[15:0]};
      2'b10: rd_ext = {{32{~acc_uns & rd_sh[31]}}, rd_sh[31:0]};
      default: rd_ext = rd_sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY <= 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    if (enter_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? '0 : rd_ext;
    end
    mem_wr = enter_resp && acc_we && !acc_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM array has no reset so contents persist across rst_n.
  always_ff @(posedge clk) begin
    if (mem_wr) mem_q[idx] <= wr_word;
  end

endmodule
